// File: rtl/divisor_seq.sv
// Sequential restoring divider plus the borrow-chain subtractor it reuses.
//
// subtrator: N-bit subtract D = A - B - B_in, B_out = borrow out.
//
// divisor_seq: unsigned N-bit division, one quotient bit per cycle.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   begin a division (accepted only when idle)
//   A, B     in   N-bit dividend / divisor, sampled with start
//   Q, R     out  registered quotient / remainder, held until next result
//   busy     out  high while iterating
//   done     out  one-cycle pulse when Q/R/div_zero are updated
//   div_zero out  set with done when the divisor was zero

module subtrator #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         B_in,
    output logic [N-1:0] D,
    output logic         B_out
);
    localparam int unsigned W = N + 1;

    logic [W-1:0] diff;

    // Extra MSB captures the borrow out of the N-bit difference.
    always_comb begin
        diff  = {1'b0, A} - {1'b0, B} - W'(B_in);
        D     = diff[N-1:0];
        B_out = diff[N];
    end
endmodule

module divisor_seq #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;       // dividend bits shift out, quotient bits shift in
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]   shifted_c;
    logic [W-1:0]   diff_c;
    logic           borrow_c;
    logic [W-1:0]   rem_step_c;
    logic [N-1:0]   a_step_c;
    logic           unused_rem_msb;

    assign shifted_c = {rem_q, a_q[N-1]};

    subtrator #(.N(W)) u_sub (
        .A     (shifted_c),
        .B     ({1'b0, b_q}),
        .B_in  (1'b0),
        .D     (diff_c),
        .B_out (borrow_c)
    );

    // Restoring step: keep the difference only when it did not borrow.
    always_comb begin
        rem_step_c = borrow_c ? shifted_c : diff_c;
        a_step_c   = {a_q[N-2:0], ~borrow_c};
    end

    // A restored remainder is always below B, so its top bit is always zero.
    assign unused_rem_msb = rem_step_c[N];

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = A;
                    b_d   = B;
                    rem_d = '0;
                    if (B == '0) begin
                        // Divide by zero: finish immediately with all-ones quotient.
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(N);
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                a_d    = a_step_c;
                rem_d  = rem_step_c[N-1:0];
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = a_step_c;
                    r_d     = rem_step_c[N-1:0];
                    dz_d    = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq (N=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_divisor_seq;
    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       div_zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t held = '0;
    exp_t mon_e;

    divisor_seq #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Monitor: compare results on done, and check Q/R/div_zero hold while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done got Q=%0d R=%0d dz=%0b, no result pending", Q, R, div_zero);
                end else begin
                    mon_e = sb.pop_front();
                    if ({Q, R, div_zero} !== mon_e) begin
                        failures++;
                        $display("FAIL result got Q=%0d R=%0d dz=%0b exp Q=%0d R=%0d dz=%0b",
                                 Q, R, div_zero, mon_e.q, mon_e.r, mon_e.dz);
                    end
                    held = mon_e;
                end
            end else if (busy) begin
                checks++;
                if ({Q, R, div_zero} !== held) begin
                    failures++;
                    $display("FAIL hold_in_calc got Q=%0d R=%0d dz=%0b exp Q=%0d R=%0d dz=%0b",
                             Q, R, div_zero, held.q, held.r, held.dz);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Issue one division, check latency and busy cycles; optional re-pulse during CALC.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input bit repulse);
        int cyc;
        int nbusy;
        bit got;
        sb.push_back({eq, er, edz});
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        B = ~b;
        cyc = 0;
        nbusy = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (done) got = 1'b1;
            if (repulse && cyc == 2) begin
                start = 1'b1;
                A = 4'd2;
                B = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", int'(got), 1);
        chk("latency", cyc, (b == 4'd0) ? 1 : 5);
        chk("busy_cycles", nbusy, (b == 4'd0) ? 0 : 4);
        if (repulse) repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({Q, R, busy, done, div_zero}), 0);
        rst = 1'b0;

        do_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1'b0);
        do_div(4'd5,  4'd7, 4'd0,  4'd5, 1'b0, 1'b0);
        do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
        do_div(4'd3,  4'd3, 4'd1,  4'd0, 1'b0, 1'b0);
        do_div(4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1'b0);
        do_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a 13/3 division.
        @(negedge clk);
        start = 1'b1;
        A = 4'd13;
        B = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_abort", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({Q, R, busy, done, div_zero}), 0);
        held = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_div(4'd2, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);

        // Full operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    do_div(4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1'b0);
                else
                    do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        chk("pending_results", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
